// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock LSB first,
// through a single full-subtractor cell with a registered borrow; start/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  // Full-subtractor cell on the current LSBs
  logic             x_bit, y_bit, d_bit, bout;
  logic [WIDTH-1:0] res_full;

  assign x_bit    = a_sr_q[0];
  assign y_bit    = b_sr_q[0];
  assign d_bit    = x_bit ^ y_bit ^ brw_q;
  assign bout     = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & brw_q);
  assign res_full = {d_bit, res_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sr_q     <= '0;
      b_sr_q     <= '0;
      res_q      <= '0;
      brw_q      <= 1'b0;
      cnt_q      <= '0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sr_q     <= a_sr_d;
      b_sr_q     <= b_sr_d;
      res_q      <= res_d;
      brw_q      <= brw_d;
      cnt_q      <= cnt_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_sr_d     = a_sr_q;
    b_sr_d     = b_sr_q;
    res_d      = res_q;
    brw_d      = brw_q;
    cnt_d      = cnt_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          brw_d   = 1'b0;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      SHIFT: begin
        res_d  = res_full;
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        brw_d  = bout;
        cnt_d  = cnt_q + CW'(1);
        // Last bit: publish result and flags together
        if (cnt_q == LAST) begin
          state_d    = DONE;
          diff_d     = res_full;
          borrow_d   = bout;
          zero_d     = (res_full == '0);
          overflow_d = (a_msb_q != b_msb_q) && (res_full[WIDTH-1] != a_msb_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed operands push expected results;
// a negedge monitor pops on done and checks that outputs hold between results.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         borrow, zero, overflow;

  res_t sb[$];
  res_t hold;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;
  logic rst_seen = 1'b0;

  logic [W-1:0] va[4];
  logic [W-1:0] vb[4];
  res_t         ve[4];
  logic [W-1:0] ba[3];
  logic [W-1:0] bb[3];
  res_t         be[3];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic res_t mk(input logic [W-1:0] d, input logic br, input logic z,
                              input logic o);
    res_t r;
    r.diff   = d;
    r.borrow = br;
    r.zero   = z;
    r.ovf    = o;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  always @(posedge clk) rst_seen <= !rst_n;

  // Monitor: result on done, otherwise last result must be held
  always @(negedge clk) begin
    res_t cur;
    res_t e;
    cur = {diff, borrow, zero, overflow};
    if (rst_seen) begin
      hold = '0;
      chk("reset_state", 32'({busy, done, cur}), 32'(0));
    end else begin
      chk("busy_done_exclusive", 32'(busy & done), 32'(0));
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("result", 32'(cur), 32'(e));
          hold = e;
        end
      end else begin
        chk("hold", 32'(cur), 32'(hold));
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while ((busy || done) && g < 40) begin
      @(negedge clk);
      g++;
    end
    chk("idle_wait", 32'(busy | done), 32'(0));
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit push,
                       input res_t e);
    wait_idle();
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    chk("accept", 32'(busy), 32'(1));
  endtask

  task automatic wait_done(input int c0);
    int g = 0;
    while (done_cnt == c0 && g < 30) begin
      @(negedge clk);
      g++;
    end
    chk("done_seen", 32'(done_cnt - c0), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int bc;
    int g;

    va = '{8'h20, 8'h80, 8'h37, 8'h00};
    vb = '{8'h50, 8'h01, 8'h37, 8'hFF};
    ve = '{mk(8'hD0, 1'b1, 1'b0, 1'b0), mk(8'h7F, 1'b0, 1'b0, 1'b1),
           mk(8'h00, 1'b0, 1'b1, 1'b0), mk(8'h01, 1'b1, 1'b0, 1'b0)};
    ba = '{8'h05, 8'h03, 8'h7F};
    bb = '{8'h03, 8'h05, 8'hFF};
    be = '{mk(8'h02, 1'b0, 1'b0, 1'b0), mk(8'hFE, 1'b1, 1'b0, 1'b0),
           mk(8'h80, 1'b1, 1'b0, 1'b1)};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({busy, done, diff, borrow, zero, overflow}), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 0x50 - 0x20 with busy-length and done-position checks
    c0 = done_cnt;
    issue(8'h50, 8'h20, 1'b1, mk(8'h30, 1'b0, 1'b0, 1'b0));
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(bc), 32'(W));
    chk("done_after_busy", 32'(done), 32'(1));
    wait_done(c0);

    for (int i = 0; i < 4; i++) begin
      c0 = done_cnt;
      issue(va[i], vb[i], 1'b1, ve[i]);
      wait_done(c0);
    end

    // Start during SHIFT must be ignored
    c0 = done_cnt;
    issue(8'h10, 8'h01, 1'b1, mk(8'h0F, 1'b0, 1'b0, 1'b0));
    repeat (2) @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(c0);
    repeat (12) @(negedge clk);
    chk("single_done", 32'(done_cnt - c0), 32'(1));
    chk("idle_after_ignore", 32'(busy | done), 32'(0));
    chk("sb_empty_ignore", 32'(sb.size()), 32'(0));

    // Reset in the middle of an operation aborts it
    c0 = done_cnt;
    issue(8'h55, 8'h11, 1'b0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_outputs", 32'({busy, done, diff, borrow, zero, overflow}), 32'(0));
    repeat (15) @(negedge clk);
    chk("no_done_after_abort", 32'(done_cnt - c0), 32'(0));
    c0 = done_cnt;
    issue(8'h01, 8'h02, 1'b1, mk(8'hFF, 1'b1, 1'b0, 1'b0));
    wait_done(c0);

    // Back-to-back with start held high
    wait_idle();
    c0    = done_cnt;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = ba[i];
      b = bb[i];
      sb.push_back(be[i]);
      g = 0;
      while (!busy && g < 30) begin
        @(negedge clk);
        g++;
      end
      while (busy && g < 60) begin
        @(negedge clk);
        g++;
      end
      chk("b2b_done", 32'(done), 32'(1));
      if (i == 2) start = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("b2b_count", 32'(done_cnt - c0), 32'(3));
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
